lut_readback_tx: RTL



---
 rtl/lut_readback_if.sv | 22 ++
 rtl/lut_readback_tx.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lut_readback_if.sv
// Byte-transmit handshake toward avr_interface plus the synchronous LUT read port.
// master = the readback block, slave = transmitter/LUT side.
interface lut_readback_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic [7:0]        tx_data;
   logic              new_tx_data;
   logic              tx_busy;
   logic              tx_block;

   modport master (
      output rd_addr, tx_data, new_tx_data,
      input  rd_data, tx_busy, tx_block
   );

   modport slave (
      input  rd_addr, tx_data, new_tx_data,
      output rd_data, tx_busy, tx_block
   );
endinterface

// File: rtl/lut_readback_tx.sv
// Dumps the projector intensity LUT over the AVR serial tx interface:
// header byte, DEPTH data bytes in address order, then an 8-bit checksum.
module lut_readback_tx #(
   parameter int         DEPTH  = 1024,
   parameter int         ADDR_W = 10,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic           CLK_50M,
   input  logic           wrst,
   input  logic           start_i,
   input  logic           lut_loaded_i,
   lut_readback_if.master tx,
   output logic           busy_o,
   output logic           done_o,
   output logic [7:0]     checksum_o
);

   typedef enum logic [2:0] {IDLE, WAIT, PULSE, GAP, ADDR, LATCH, DONE} state_e;
   typedef enum logic [1:0] {HDR, DATA, CSUM} byte_sel_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   byte_sel_e         byte_sel_q, byte_sel_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              new_tx_data_q, new_tx_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        checksum_q, checksum_d;

   // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      byte_sel_d    = byte_sel_q;
      rd_addr_d     = rd_addr_q;
      tx_data_d     = tx_data_q;
      new_tx_data_d = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      checksum_d    = checksum_q;

      unique case (state_q)
         IDLE: begin
            if (start_i && lut_loaded_i) begin
               tx_data_d  = HEADER;
               checksum_d = 8'h00;
               rd_addr_d  = '0;
               busy_d     = 1'b1;
               byte_sel_d = HDR;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            // Strobe register is loaded on the way into PULSE so it is high exactly during PULSE.
            if (!tx.tx_busy && !tx.tx_block) begin
               new_tx_data_d = 1'b1;
               state_d       = PULSE;
            end
         end
         PULSE: state_d = GAP;
         GAP: begin
            // tx_busy is not looked at here: the transmitter raises it a cycle after the strobe.
            unique case (byte_sel_q)
               HDR: state_d = ADDR;
               DATA: begin
                  if (rd_addr_q != LAST_ADDR) begin
                     rd_addr_d = rd_addr_q + 1'b1;
                     state_d   = ADDR;
                  end else begin
                     tx_data_d  = checksum_q;
                     byte_sel_d = CSUM;
                     state_d    = WAIT;
                  end
               end
               default: state_d = DONE;
            endcase
         end
         ADDR: state_d = LATCH;
         LATCH: begin
            tx_data_d  = tx.rd_data;
            checksum_d = checksum_q + tx.rd_data;
            byte_sel_d = DATA;
            state_d    = WAIT;
         end
         DONE: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            rd_addr_d = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
   always_ff @(posedge CLK_50M or posedge wrst) begin
      if (wrst) begin
         state_q       <= IDLE;
         byte_sel_q    <= HDR;
         rd_addr_q     <= '0;
         tx_data_q     <= 8'h00;
         new_tx_data_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         checksum_q    <= 8'h00;
      end else begin
         state_q       <= state_d;
         byte_sel_q    <= byte_sel_d;
         rd_addr_q     <= rd_addr_d;
         tx_data_q     <= tx_data_d;
         new_tx_data_q <= new_tx_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         checksum_q    <= checksum_d;
      end
   end

   assign tx.rd_addr     = rd_addr_q;
   assign tx.tx_data     = tx_data_q;
   assign tx.new_tx_data = new_tx_data_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign checksum_o     = checksum_q;

endmodule
